// File: rtl/fir_pkg.sv
// Shared FIR constants, reader state type and flat-bus slice helper.
package fir_pkg;
  localparam int FIR_DATA_W = 8;
  localparam int FIR_DEPTH  = 5;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} rd_state_e;

  function automatic logic [FIR_DATA_W-1:0] fir_entry(
    input logic [FIR_DATA_W*FIR_DEPTH-1:0] flat,
    input int                              k
  );
    return flat[k*FIR_DATA_W +: FIR_DATA_W];
  endfunction
endpackage

// File: rtl/fir_entry_mux.sv
// Combinational selector: entry idx_i of a flat DATA_W*DEPTH bus.
module fir_entry_mux #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = 3
) (
  input  logic [DATA_W*DEPTH-1:0] flat_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [DATA_W-1:0]       data_o
);
  logic [DEPTH-1:0][DATA_W-1:0] ent;
  assign ent = flat_i;

  // Out-of-range index reads as zero.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < DEPTH; k++)
      if (idx_i == IDX_W'(k)) data_o = ent[k];
  end
endmodule

// File: rtl/fir_result_reader.sv
// Snapshots the flat result memory on start and streams entries out over
// valid/ready, accumulating a wrapping sum and pulsing done after the last.
module fir_result_reader #(
  parameter int DATA_W = fir_pkg::FIR_DATA_W,
  parameter int DEPTH  = fir_pkg::FIR_DEPTH,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W*DEPTH-1:0] i_mem_flat,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_data,
  output logic [IDX_W-1:0]        o_index,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [DATA_W-1:0]       o_sum
);
  import fir_pkg::*;

  rd_state_e               state_q, state_d;
  logic [DATA_W*DEPTH-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       sum_q, sum_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       ent;
  logic                    sending, at_last;

  fir_entry_mux #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_mux (
    .flat_i (snap_q),
    .idx_i  (idx_q),
    .data_o (ent)
  );

  assign sending = (state_q == SEND);
  assign at_last = (idx_q == IDX_W'(DEPTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          snap_d  = i_mem_flat;
          idx_d   = '0;
          sum_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A handshake coinciding with abort was accepted downstream, so it still counts.
        if (i_ready) begin
          sum_d = sum_q + ent;
          idx_d = idx_q + IDX_W'(1);
        end
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_ready && at_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_valid = sending;
  assign o_busy  = sending;
  assign o_data  = sending ? ent : '0;
  assign o_index = sending ? idx_q : '0;
  assign o_last  = sending && at_last;
  assign o_done  = done_q;
  assign o_sum   = sum_q;
endmodule

// File: tb/tb_fir_result_reader.sv
// Bench for fir_result_reader: vector table, randomized streams against a
// queue-free reference, and directed back-to-back / reset sequences.
module tb_fir_result_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] i_mem_flat;
  logic        i_start, i_abort, i_ready;
  logic        o_valid, o_last, o_busy, o_done;
  logic [7:0]  o_data, o_sum;
  logic [2:0]  o_index;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  fir_result_reader dut (
    .clk(clk), .rst_n(rst_n), .i_mem_flat(i_mem_flat), .i_start(i_start),
    .i_abort(i_abort), .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data),
    .o_index(o_index), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
    .o_sum(o_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [39:0] flat;
    logic [39:0] after;
    int          rmode;
    int          abort_at;
    logic [7:0]  sum;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (o_done) done_cnt++;
  endtask

  function automatic logic [7:0] ent(input logic [39:0] f, input int k);
    return f[k*8 +: 8];
  endfunction

  // Reference: entries leave in index order; every accepted entry adds to the
  // running sum; the stream ends on abort (no done) or after entry 4 (done).
  task automatic run_stream(input logic [39:0] flat, input logic [39:0] after,
                            input int rmode, input int abort_at,
                            output logic [7:0] msum);
    int  k;
    logic rdy;
    msum = 8'h00;
    k = 0;
    i_mem_flat = flat; i_start = 1'b1; i_abort = 1'b0; i_ready = 1'b0;
    step();
    i_start = 1'b0;
    i_mem_flat = after;
    for (int cyc = 0; cyc < 300; cyc++) begin
      chk("valid", o_valid, 1);
      chk("busy", o_busy, 1);
      chk("data", o_data, ent(flat, k));
      chk("index", o_index, k);
      chk("last", o_last, k == 4);
      chk("psum", o_sum, msum);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_ready = rdy;
      i_abort = rdy && (k == abort_at);
      step();
      if (rdy) begin
        msum = msum + ent(flat, k);
        if (k == abort_at) begin
          i_abort = 1'b0; i_ready = 1'b0;
          chk("abort_valid", o_valid, 0);
          chk("abort_nodone", o_done, 0);
          chk("abort_sum", o_sum, msum);
          return;
        end
        if (k == 4) begin
          i_ready = 1'b0;
          chk("done", o_done, 1);
          chk("done_valid", o_valid, 0);
          chk("done_sum", o_sum, msum);
          step();
          chk("done_pulse", o_done, 0);
          return;
        end
        k++;
      end
    end
    chk("stream_timeout", 1, 0);
  endtask

  initial begin
    logic [7:0]  ms;
    logic [39:0] fa, fb, rf;
    int          ab, rm;
    rst_n = 1'b0; i_mem_flat = '0; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    #2;
    chk("rst_valid", o_valid, 0); chk("rst_data", o_data, 0);
    chk("rst_index", o_index, 0); chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);   chk("rst_done", o_done, 0);
    chk("rst_sum", o_sum, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    tbl[0] = '{40'h0504030201, 40'h0504030201, 0, -1, 8'h0F};
    tbl[1] = '{40'h0504030201, 40'h0504030201, 1, -1, 8'h0F};
    tbl[2] = '{40'hFFFFFFFFFF, 40'h0000000000, 0, -1, 8'hFB};
    tbl[3] = '{40'h0403020100, 40'h0403020100, 0,  2, 8'h03};
    tbl[4] = '{40'h8899AABBCC, 40'h1234567890, 2, -1, 8'h52};
    for (int i = 0; i < 5; i++) begin
      run_stream(tbl[i].flat, tbl[i].after, tbl[i].rmode, tbl[i].abort_at, ms);
      chk($sformatf("tbl%0d_sum", i), o_sum, tbl[i].sum);
    end

    // Sum held in IDLE; abort beats start in IDLE.
    i_start = 1'b1; i_abort = 1'b1; i_ready = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    chk("idle_abort_valid", o_valid, 0);
    step();
    chk("idle_hold_valid", o_valid, 0);
    chk("idle_hold_sum", o_sum, 8'h52);

    for (int r = 0; r < 20; r++) begin
      rf = {$urandom, $urandom};
      rm = $urandom_range(0, 2);
      ab = $urandom_range(0, 7);
      if (ab > 4) ab = -1;
      run_stream(rf, {$urandom, $urandom}, rm, ab, ms);
      chk("rand_sum", o_sum, ms);
    end

    // Start while busy ignored; start on done cycle accepted back-to-back.
    fa = 40'h1122334455; fb = 40'h0A0B0C0D0E;
    done_cnt = 0;
    i_ready = 1'b1; i_mem_flat = fa; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("b2b_a_data", o_data, ent(fa, k));
      i_start = (k == 1 || k == 4);
      if (k == 1) i_mem_flat = fb;
      step();
    end
    chk("b2b_done1", o_done, 1);
    chk("b2b_gap_valid", o_valid, 0);
    i_start = 1'b1; i_mem_flat = fb;
    step();
    i_start = 1'b0;
    chk("b2b_second_valid", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("b2b_b_data", o_data, ent(fb, k));
      step();
    end
    chk("b2b_done2", o_done, 1);
    chk("b2b_sum", o_sum, 8'h3C);
    i_ready = 1'b0;
    step(); step();
    chk("b2b_done_cnt", done_cnt, 2);

    // Reset asserted mid-stream after two handshakes.
    i_mem_flat = fa; i_start = 1'b1; i_ready = 1'b0;
    step();
    i_start = 1'b0; i_ready = 1'b1;
    step(); step();
    chk("mid_index", o_index, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", o_valid, 0); chk("mrst_data", o_data, 0);
    chk("mrst_index", o_index, 0); chk("mrst_last", o_last, 0);
    chk("mrst_busy", o_busy, 0);   chk("mrst_done", o_done, 0);
    chk("mrst_sum", o_sum, 0);
    #3 rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_valid", o_valid, 0);
      chk("post_rst_sum", o_sum, 0);
    end
    chk("post_rst_nodone", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
